smvm_stream_tx: RTL

Transmitter for the SMVM serial input protocol. Takes one job command (matrix shape), a dense-vector source stream and a nonzero-entry source stream, all with valid/ready handshakes, and serialises them onto the 8-bit val / 1-bit ipv / valid link consumed by SMVM. It pads the entry list to a multiple of K and enforces the inter-frame idle gap SMVM needs for CAL/RST.

---
 rtl/smvm_pkg.sv | 36 +++
 rtl/smvm_stream_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/smvm_pkg.sv
// Shared definitions for the SMVM link: shape limits, field widths, state codes
// and the 9-bit field packing used by both the transmitter and SMVM itself.
package smvm_pkg;

   localparam int SMVM_K          = 4;
   localparam int SMVM_MAX_SHAPE  = 256;
   localparam int SMVM_GAP_CYCLES = 8;
   localparam int FIELD_W         = 9;
   localparam int VAL_W           = 8;
   localparam int OUT_W           = 12;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_HDR_ROWS = 4'd1;
   localparam logic [3:0] ST_HDR_COLS = 4'd2;
   localparam logic [3:0] ST_VEC      = 4'd3;
   localparam logic [3:0] ST_NZ_VAL   = 4'd4;
   localparam logic [3:0] ST_NZ_IDX   = 4'd5;
   localparam logic [3:0] ST_PAD_VAL  = 4'd6;
   localparam logic [3:0] ST_PAD_IDX  = 4'd7;
   localparam logic [3:0] ST_GAP      = 4'd8;

   // A link field carries the value in its top 8 bits and the ipv bit in bit 0
   function automatic logic [FIELD_W-1:0] pack_field(input logic [VAL_W-1:0] val,
                                                     input logic ipv);
      return {val, ipv};
   endfunction

   function automatic logic [VAL_W-1:0] unpack_val(input logic [FIELD_W-1:0] field);
      return field[FIELD_W-1:1];
   endfunction

   function automatic logic unpack_ipv(input logic [FIELD_W-1:0] field);
      return field[0];
   endfunction

endpackage

// File: rtl/smvm_stream_tx.sv
// Serialises one SMVM job (shape header, dense vector, padded entry list) onto the
// 8-bit val / ipv / valid link, then holds the link idle long enough for CAL/RST.
module smvm_stream_tx
   import smvm_pkg::*;
#(
   parameter int K          = SMVM_K,
   parameter int GAP_CYCLES = SMVM_GAP_CYCLES,
   parameter int MAX_SHAPE  = SMVM_MAX_SHAPE,
   localparam int SHAPE_W   = $clog2(MAX_SHAPE + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [SHAPE_W-1:0] cmd_rows,
   input  logic [SHAPE_W-1:0] cmd_cols,
   input  logic               vec_valid,
   output logic               vec_ready,
   input  logic [VAL_W-1:0]   vec_data,
   input  logic               nz_valid,
   output logic               nz_ready,
   input  logic [VAL_W-1:0]   nz_val,
   input  logic [SHAPE_W-1:0] nz_col,
   input  logic               nz_ipv,
   input  logic               nz_last,
   output logic [VAL_W-1:0]   tx_val,
   output logic               tx_ipv,
   output logic               tx_valid,
   output logic               busy,
   output logic               underrun
);

   localparam int GRP_W = (K > 1) ? $clog2(K) : 1;
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [SHAPE_W-1:0] ONE_S   = 1;
   localparam logic [GRP_W-1:0]   ONE_G   = 1;
   localparam logic [GAP_W-1:0]   ONE_GAP = 1;

   logic [3:0]         state;
   logic [SHAPE_W-1:0] rows_q;
   logic [SHAPE_W-1:0] cols_q;
   logic [SHAPE_W-1:0] col_q;
   logic               last_q;
   logic [SHAPE_W-1:0] vec_cnt;
   logic [GRP_W-1:0]   grp_cnt;
   logic [GRP_W-1:0]   grp_next;
   logic [GAP_W-1:0]   gap_cnt;
   logic               vec_last;
   logic               gap_last;

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign vec_ready = (state == ST_VEC);
   assign nz_ready  = (state == ST_NZ_VAL);

   // Entry counter advances once per (val, col) pair, pads included
   always_comb begin
      grp_next = grp_cnt + ONE_G;
      if (grp_cnt == GRP_W'(K - 1))
         grp_next = '0;
      vec_last = (vec_cnt == (cols_q - ONE_S));
      gap_last = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
   end

   // Link words are registered; each state emits the word for its own slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         rows_q   <= '0;
         cols_q   <= '0;
         col_q    <= '0;
         last_q   <= 1'b0;
         vec_cnt  <= '0;
         grp_cnt  <= '0;
         gap_cnt  <= '0;
         underrun <= 1'b0;
         tx_val   <= '0;
         tx_ipv   <= 1'b0;
         tx_valid <= 1'b0;
      end else begin
         tx_val   <= '0;
         tx_ipv   <= 1'b0;
         tx_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  rows_q   <= cmd_rows;
                  cols_q   <= cmd_cols;
                  underrun <= 1'b0;
                  vec_cnt  <= '0;
                  grp_cnt  <= '0;
                  gap_cnt  <= '0;
                  state    <= ST_HDR_ROWS;
               end
            end
            ST_HDR_ROWS: begin
               {tx_val, tx_ipv} <= rows_q;
               tx_valid         <= 1'b1;
               state            <= ST_HDR_COLS;
            end
            ST_HDR_COLS: begin
               {tx_val, tx_ipv} <= cols_q;
               tx_valid         <= 1'b1;
               state            <= ST_VEC;
            end
            ST_VEC: begin
               tx_valid <= 1'b1;
               if (vec_valid)
                  {tx_val, tx_ipv} <= pack_field(vec_data, 1'b0);
               else
                  underrun <= 1'b1;
               vec_cnt <= vec_cnt + ONE_S;
               if (vec_last)
                  state <= ST_NZ_VAL;
            end
            // A starved slot becomes a zero pad entry so the frame keeps its cadence
            ST_NZ_VAL: begin
               tx_valid <= 1'b1;
               if (nz_valid) begin
                  {tx_val, tx_ipv} <= pack_field(nz_val, nz_ipv);
                  col_q            <= nz_col;
                  last_q           <= nz_last;
               end else begin
                  col_q    <= '0;
                  last_q   <= 1'b0;
                  underrun <= 1'b1;
               end
               state <= ST_NZ_IDX;
            end
            ST_NZ_IDX: begin
               {tx_val, tx_ipv} <= col_q;
               tx_valid         <= 1'b1;
               grp_cnt          <= grp_next;
               if (last_q && (grp_next == '0))
                  state <= ST_GAP;
               else if (last_q)
                  state <= ST_PAD_VAL;
               else
                  state <= ST_NZ_VAL;
            end
            ST_PAD_VAL: begin
               tx_valid <= 1'b1;
               state    <= ST_PAD_IDX;
            end
            ST_PAD_IDX: begin
               tx_valid <= 1'b1;
               grp_cnt  <= grp_next;
               state    <= (grp_next == '0) ? ST_GAP : ST_PAD_VAL;
            end
            ST_GAP: begin
               if (gap_last) begin
                  gap_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + ONE_GAP;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
